weighted_rr_arbiter: RTL and testbench



---
 rtl/weighted_rr_arbiter_pkg.sv | 14 +
 rtl/rotating_priority_encoder.sv | 28 ++
 rtl/weighted_rr_arbiter.sv | 96 +++++++++
 tb/tb_weighted_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared defaults, weight type and effective-weight helper for the weighted round-robin arbiter.
package wrr_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF  = 4;
    localparam int unsigned WEIGHT_W_DEF = 4;

    typedef logic [WEIGHT_W_DEF-1:0] weight_t;

    // A programmed weight of zero still earns one grant, so no requester can starve itself.
    function automatic int unsigned eff_weight(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rotating_priority_encoder.sv
// Combinational first-set-bit search starting at ptr and wrapping modulo NUM_REQ.
module rotating_priority_encoder #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int p;
            p = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[p]) begin
                found     = 1'b1;
                idx       = IDX_W'(p);
                onehot[p] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: a search-mode winner may hold the grant for up to
// `weight` consecutive accepted cycles while it keeps requesting.
module weighted_rr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        srst_i,
    input  logic                        allow_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*WEIGHT_W-1:0] weights_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [IDX_W-1:0]            gnt_idx_o,
    output logic                        gnt_found_o
);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] BURST  = 1'b1;

    logic [IDX_W-1:0]    ptr_q;
    logic                own_vld_q;
    logic [IDX_W-1:0]    own_q;
    logic [WEIGHT_W-1:0] credit_q;

    logic [0:0]          state;
    logic                burst_hit;
    logic [NUM_REQ-1:0]  enc_onehot;
    logic [IDX_W-1:0]    enc_idx;
    logic                enc_found;
    logic [WEIGHT_W-1:0] sel_weight;
    int unsigned         sel_eff;
    logic [IDX_W-1:0]    next_ptr;

    rotating_priority_encoder #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_enc (
        .req    (req_i),
        .ptr    (ptr_q),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .found  (enc_found)
    );

    assign state      = own_vld_q ? BURST : SEARCH;
    assign burst_hit  = (state == BURST) && req_i[own_q];
    assign sel_weight = weights_i[int'(enc_idx)*WEIGHT_W +: WEIGHT_W];
    assign sel_eff    = eff_weight(32'(sel_weight));
    assign next_ptr   = (int'(enc_idx) == NUM_REQ-1) ? '0 : enc_idx + 1'b1;

    // A dropped owner falls through to the search, which already starts just past it.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_found_o = 1'b0;
        if (!srst_i && allow_i) begin
            if (burst_hit) begin
                gnt_o[own_q] = 1'b1;
                gnt_idx_o    = own_q;
                gnt_found_o  = 1'b1;
            end else if (enc_found) begin
                gnt_o       = enc_onehot;
                gnt_idx_o   = enc_idx;
                gnt_found_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            ptr_q     <= '0;
            own_vld_q <= 1'b0;
            own_q     <= '0;
            credit_q  <= '0;
        end else if (allow_i && gnt_found_o) begin
            if (burst_hit) begin
                credit_q <= credit_q - 1'b1;
                if (credit_q == WEIGHT_W'(1))
                    own_vld_q <= 1'b0;
            end else begin
                ptr_q <= next_ptr;
                if (sel_eff > 1) begin
                    own_q     <= enc_idx;
                    own_vld_q <= 1'b1;
                    credit_q  <= WEIGHT_W'(sel_eff - 1);
                end else begin
                    own_vld_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_weighted_rr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

    logic              clk = 1'b0;
    logic              srst;
    logic              allow;
    logic [N-1:0]      req;
    logic [N*WW-1:0]   weights;
    logic [N-1:0]      gnt;
    logic [1:0]        gnt_idx;
    logic              gnt_found;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: next search start, current burst holder (-1 none), grants still owed.
    int m_ptr   = 0;
    int m_owner = -1;
    int m_left  = 0;

    always #5 clk = ~clk;

    weighted_rr_arbiter #(
        .NUM_REQ  (N),
        .WEIGHT_W (WW)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst),
        .allow_i     (allow),
        .req_i       (req),
        .weights_i   (weights),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_found_o (gnt_found)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int weight_of(input int k);
        int w;
        w = int'(weights[k*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit model_holds();
        return (m_owner >= 0) && req[m_owner];
    endfunction

    function automatic int model_pick();
        if (srst || !allow) return -1;
        if (model_holds()) return m_owner;
        for (int off = 0; off < N; off++)
            if (req[(m_ptr + off) % N]) return (m_ptr + off) % N;
        return -1;
    endfunction

    // One clock: drive, check the combinational grant mid-cycle, then advance the model.
    task automatic cycle(input bit rst_v, input bit allow_v, input logic [N-1:0] req_v,
                         input int exp_vec);
        int g;
        bit held;
        srst  = rst_v;
        allow = allow_v;
        req   = req_v;
        #2;
        g    = model_pick();
        held = model_holds();
        check("gnt", int'(gnt), (g < 0) ? 0 : (1 << g));
        check("gnt_idx", int'(gnt_idx), (g < 0) ? 0 : g);
        check("gnt_found", int'(gnt_found), (g < 0) ? 0 : 1);
        check("found_vs_or", int'(gnt_found), int'(|gnt));
        if (exp_vec >= 0)
            check("directed_gnt", int'(gnt), exp_vec);
        @(posedge clk);
        if (srst) begin
            m_ptr = 0; m_owner = -1; m_left = 0;
        end else if (g >= 0) begin
            if (held) begin
                m_left--;
                if (m_left == 0) m_owner = -1;
            end else begin
                m_ptr = (g + 1) % N;
                if (weight_of(g) > 1) begin
                    m_owner = g;
                    m_left  = weight_of(g) - 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
        #1;
    endtask

    task automatic run_seq(input logic [N-1:0] req_v, input int exp_q[$]);
        foreach (exp_q[i]) cycle(1'b0, 1'b1, req_v, exp_q[i]);
    endtask

    initial begin
        srst = 1'b1; allow = 1'b1; req = '0; weights = 16'h1111;

        // Reset forces no grant even with all requesting.
        cycle(1'b1, 1'b1, 4'b1111, 0);
        cycle(1'b1, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, '{1, 2, 4, 8, 1});

        // Weights {3,1,2,1}.
        weights = 16'h1213;
        cycle(1'b1, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, '{1, 1, 1, 2, 4, 4, 8, 1, 1, 1});

        // Owner drops after two of four grants.
        weights = 16'h1114;
        cycle(1'b1, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, '{1, 1});
        run_seq(4'b1110, '{2, 4, 8, 2});

        // allow outage in the middle of a burst.
        weights = 16'h1113;
        cycle(1'b1, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, '{1});
        cycle(1'b0, 1'b0, 4'b1111, 0);
        cycle(1'b0, 1'b0, 4'b1111, 0);
        run_seq(4'b1111, '{1, 1, 2});

        // Weight 0 on a lone requester.
        weights = 16'h1011;
        cycle(1'b1, 1'b1, 4'b0100, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'b0100, 4);

        // Reset in the middle of a burst discards it.
        weights = 16'h1115;
        cycle(1'b1, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, '{1, 1});
        cycle(1'b1, 1'b1, 4'b1111, 0);
        run_seq(4'b1111, '{1, 1, 1, 1, 1, 2});

        // Random traffic, weights changing occasionally (including mid-burst).
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) weights = 16'($urandom);
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0),
                  4'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
